vend_ctrl: RTL

- Parametrised N-channel vending transaction core; successor to the fixed 4-slot stock/pay/change logic.
- Per-channel stock counters with capacity limit and restocking.
- Runtime per-channel price, coin accumulation, purchase and refund FSM with inactivity timeout, change computation.
- Feeds the seven-segment display and the input_process key/button decoders.

---
 rtl/vend_pkg.sv | 33 +++
 rtl/vend_channel.sv | 50 +++++
 rtl/vend_ctrl.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/vend_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | vend_pkg : shared FSM states and channel-select helpers          |
// | Rev 1.0                                                          |
// +-----------------------------------------------------------------+
package vend_pkg;

  localparam int MAX_NCH = 16;
  localparam int IDX_W   = 4;

  typedef logic [1:0] state_t;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_COLLECT = 2'd1;
  localparam logic [1:0] ST_VEND    = 2'd2;
  localparam logic [1:0] ST_REFUND  = 2'd3;

  function automatic logic is_onehot(input logic [MAX_NCH-1:0] v);
    return (v != '0) && ((v & (v - MAX_NCH'(1))) == '0);
  endfunction

  // Only meaningful when is_onehot(v) holds.
  function automatic logic [IDX_W-1:0] onehot_idx(input logic [MAX_NCH-1:0] v);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < MAX_NCH; i++) begin
      if (v[i]) idx = idx | IDX_W'(i);
    end
    return idx;
  endfunction

endpackage
`default_nettype wire

// File: rtl/vend_channel.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | vend_channel : one stock counter with saturating restock         |
// | Rev 1.0                                                          |
// +-----------------------------------------------------------------+
module vend_channel #(
  parameter int CAP = 15,
  parameter int CW  = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          rs_en,
  input  logic [CW-1:0] rs_qty,
  input  logic          dec,
  output logic [CW-1:0] stock,
  output logic [CW-1:0] room,
  output logic          ovf
);

  logic [CW-1:0] stock_q, stock_d;
  logic [CW-1:0] room_w;

  assign room_w = CW'(CAP) - stock_q;

  // Restock and dispense never coincide: restock is only enabled while idle.
  always_comb begin
    stock_d = stock_q;
    ovf     = 1'b0;
    if (rs_en) begin
      if (rs_qty > room_w) begin
        stock_d = CW'(CAP);
        ovf     = 1'b1;
      end else begin
        stock_d = stock_q + rs_qty;
      end
    end else if (dec && (stock_q != '0)) begin
      stock_d = stock_q - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stock_q <= '0;
    else        stock_q <= stock_d;
  end

  assign stock = stock_q;
  assign room  = room_w;

endmodule
`default_nettype wire

// File: rtl/vend_ctrl.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | vend_ctrl : N-channel vending core (stock, pay, vend, refund)    |
// | Rev 1.0                                                          |
// +-----------------------------------------------------------------+
module vend_ctrl
  import vend_pkg::*;
#(
  parameter int  NCH     = 4,
  parameter int  CAP     = 15,
  parameter int  CW      = 4,
  parameter int  MW      = 8,
  parameter int  TIMEOUT = 1000,
  localparam int CHW     = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NCH-1:0]    sel,
  input  logic [NCH*MW-1:0] price,
  input  logic              coin_valid,
  input  logic [MW-1:0]     coin_val,
  input  logic              cancel,
  input  logic              rs_valid,
  input  logic [CHW-1:0]    rs_ch,
  input  logic [CW-1:0]     rs_qty,
  output logic [NCH*CW-1:0] stock,
  output logic [NCH*CW-1:0] room,
  output logic [MW-1:0]     paid,
  output logic [MW-1:0]     remain,
  output logic [CHW-1:0]    cur_ch,
  output logic              busy,
  output logic              vend_valid,
  output logic              chg_valid,
  output logic [MW-1:0]     chg_amt,
  output logic              err_soldout,
  output logic              coin_reject,
  output logic              rs_ovf
);

  localparam int TW    = $clog2(TIMEOUT);
  localparam int NSLOT = 2 ** CHW;

  state_t         state_q, state_d;
  logic [CHW-1:0] cur_ch_q, cur_ch_d;
  logic [MW-1:0]  paid_q, paid_d;
  logic [MW-1:0]  chg_amt_q, chg_amt_d;
  logic [TW-1:0]  timer_q, timer_d;
  logic           busy_q, busy_d;
  logic           vend_valid_q, vend_valid_d;
  logic           chg_valid_q, chg_valid_d;
  logic           err_soldout_q, err_soldout_d;
  logic           coin_reject_q, coin_reject_d;
  logic           rs_ovf_q, rs_ovf_d;

  logic [CW-1:0]      stock_w [NSLOT];
  logic [NSLOT-1:0]   ch_exists;
  logic [NSLOT-1:0]   ovf_w;
  logic [MAX_NCH-1:0] sel_ext;
  logic [CHW-1:0]     sel_idx;
  logic               sel_ok;
  logic [MW-1:0]      cur_price;
  logic               paid_enough;
  logic               rs_accept;
  logic [MW:0]        coin_sum;
  logic               coin_ok;

  // Index space is padded to a power of two so any rs_ch/sel_idx value is a legal index.
  generate
    for (genvar i = 0; i < NSLOT; i++) begin : g_slot
      if (i < NCH) begin : g_ch
        logic rs_en_w, dec_w;
        assign ch_exists[i] = 1'b1;
        assign rs_en_w      = rs_accept && (rs_ch == CHW'(i));
        assign dec_w        = (state_q == ST_VEND) && (cur_ch_q == CHW'(i));

        vend_channel #(
          .CAP (CAP),
          .CW  (CW)
        ) u_channel (
          .clk    (clk),
          .rst_n  (rst_n),
          .rs_en  (rs_en_w),
          .rs_qty (rs_qty),
          .dec    (dec_w),
          .stock  (stock_w[i]),
          .room   (room[i*CW +: CW]),
          .ovf    (ovf_w[i])
        );

        assign stock[i*CW +: CW] = stock_w[i];
      end else begin : g_pad
        assign ch_exists[i] = 1'b0;
        assign stock_w[i]   = '0;
        assign ovf_w[i]     = 1'b0;
      end
    end
  endgenerate

  always_comb begin
    sel_ext          = '0;
    sel_ext[NCH-1:0] = sel;
  end

  assign sel_ok      = is_onehot(sel_ext);
  assign sel_idx     = CHW'(onehot_idx(sel_ext));
  assign cur_price   = price[cur_ch_q*MW +: MW];
  assign paid_enough = (paid_q >= cur_price);
  assign rs_accept   = rs_valid && (state_q == ST_IDLE) && ch_exists[rs_ch];
  assign coin_sum    = {1'b0, paid_q} + {1'b0, coin_val};

  always_comb begin
    state_d       = state_q;
    cur_ch_d      = cur_ch_q;
    paid_d        = paid_q;
    chg_amt_d     = chg_amt_q;
    timer_d       = timer_q;
    vend_valid_d  = 1'b0;
    chg_valid_d   = 1'b0;
    err_soldout_d = 1'b0;
    coin_reject_d = 1'b0;
    coin_ok       = 1'b0;
    rs_ovf_d      = rs_accept && (|ovf_w);

    case (state_q)
      ST_IDLE: begin
        coin_reject_d = coin_valid;
        // Selection looks at pre-restock stock even if a restock lands this cycle.
        if (sel_ok) begin
          if (stock_w[sel_idx] != '0) begin
            cur_ch_d = sel_idx;
            paid_d   = '0;
            timer_d  = '0;
            state_d  = ST_COLLECT;
          end else begin
            err_soldout_d = 1'b1;
          end
        end
      end

      ST_COLLECT: begin
        if (coin_valid) begin
          if (coin_sum[MW]) begin
            coin_reject_d = 1'b1;
          end else begin
            paid_d  = coin_sum[MW-1:0];
            coin_ok = 1'b1;
          end
        end
        timer_d = coin_ok ? '0 : timer_q + TW'(1);

        if (cancel) begin
          state_d = ST_REFUND;
        end else if (!coin_ok && (timer_q == TW'(TIMEOUT - 1))) begin
          state_d = ST_REFUND;
        end else if (paid_enough) begin
          state_d = ST_VEND;
        end
      end

      ST_VEND: begin
        coin_reject_d = coin_valid;
        vend_valid_d  = 1'b1;
        chg_valid_d   = 1'b1;
        chg_amt_d     = paid_enough ? (paid_q - cur_price) : '0;
        paid_d        = '0;
        state_d       = ST_IDLE;
      end

      default: begin
        coin_reject_d = coin_valid;
        chg_valid_d   = 1'b1;
        chg_amt_d     = paid_q;
        paid_d        = '0;
        state_d       = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      cur_ch_q      <= '0;
      paid_q        <= '0;
      chg_amt_q     <= '0;
      timer_q       <= '0;
      busy_q        <= 1'b0;
      vend_valid_q  <= 1'b0;
      chg_valid_q   <= 1'b0;
      err_soldout_q <= 1'b0;
      coin_reject_q <= 1'b0;
      rs_ovf_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      cur_ch_q      <= cur_ch_d;
      paid_q        <= paid_d;
      chg_amt_q     <= chg_amt_d;
      timer_q       <= timer_d;
      busy_q        <= busy_d;
      vend_valid_q  <= vend_valid_d;
      chg_valid_q   <= chg_valid_d;
      err_soldout_q <= err_soldout_d;
      coin_reject_q <= coin_reject_d;
      rs_ovf_q      <= rs_ovf_d;
    end
  end

  assign paid        = paid_q;
  assign remain      = paid_enough ? '0 : (cur_price - paid_q);
  assign cur_ch      = cur_ch_q;
  assign busy        = busy_q;
  assign vend_valid  = vend_valid_q;
  assign chg_valid   = chg_valid_q;
  assign chg_amt     = chg_amt_q;
  assign err_soldout = err_soldout_q;
  assign coin_reject = coin_reject_q;
  assign rs_ovf      = rs_ovf_q;

endmodule
`default_nettype wire
